bitboard_scanner: RTL and testbench
===================================

# bitboard_scanner

Sequential consumer of 32-bit checkers bitboards such as the move and jump masks the ALU's diagonal-shift ops produce. It accepts one bitboard per handshake and emits the square index of every set bit, lowest index first, one index per cycle on a valid/ready stream. It sits between the CPU datapath (memory-mapped board registers) and the move-list builder and AI search logic. A zero board produces a single "none" beat so that consumers always see a terminating beat.

## Interface
Parameters:
- BOARD_W, 32, bitboard width (one bit per playable square).
- IDX_W, 5, index width; must equal clog2(BOARD_W).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset); one clock, reset is asynchronous and active-low.
- in_valid  in  1  bitboard offered.
- in_ready  out  1  scanner can accept a bitboard this cycle.
- in_board  in  BOARD_W  bitboard; bit i = square i.
- out_valid  out  1  index beat valid.
- out_ready  in  1  consumer accepts beat.
- out_index  out  IDX_W  square index of the current set bit (0 when out_none=1).
- out_seq  out  IDX_W  beat ordinal within the current board, starting at 0.
- out_last  out  1  final beat of the current board.
- out_none  out  1  board was zero; beat carries no square.
- busy  out  1  a board is held (state != IDLE).

## Operation
- Registers: board_q[BOARD_W], seq_q[IDX_W], none_q, and state in {IDLE, EMIT}.
- IDLE: in_ready=1 and out_valid=0. On in_valid, capture board_q<=in_board, seq_q<=0, none_q<=(in_board==0), then go to EMIT.
- EMIT: out_valid=1.
  - out_index = index of the lowest set bit of board_q, or 0 if none_q.
  - out_last = none_q | ((board_q & (board_q-1))==0).
  - out_seq = seq_q; out_none = none_q.
- Beat transfer occurs when out_valid & out_ready:
  - Not last: board_q<=board_q & (board_q-1) and seq_q<=seq_q+1.
  - Last: if in_valid, capture the new board and stay in EMIT; otherwise go to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This allows back-to-back boards with no bubble.
- Backpressure: while out_ready=0, all outputs hold stable and no state changes.
- A full board (all ones) yields 32 beats, seq 0..31. seq_q never wraps, because at most BOARD_W beats occur per board.
- in_board is ignored whenever in_ready=0.
- Reset takes effect mid-board: the held board is discarded and no residual beats are emitted.

## Timing
- Reset values: state=IDLE, board_q=0, seq_q=0, none_q=0. Outputs: in_ready=1, out_valid=0, out_index=0, out_seq=0, out_last=0, out_none=0, busy=0.
- Latency: board accepted at edge N gives the first beat valid in cycle N+1.
- Throughput: one beat per cycle under out_ready=1, so a board costs max(popcount,1) cycles.
- Outputs are decoded from registers only. There is no combinational path from in_* to out_*. in_ready depends combinationally on out_ready.

## Structure
- Shared package/header `checkers_pkg`: BOARD_W=32, IDX_W=5, and state encodings SCAN_IDLE=1'b0, SCAN_EMIT=1'b1. The ALU and move-list builder reuse BOARD_W.
- One combinational sub-module, `lsb_index`: a BOARD_W→IDX_W lowest-set-bit priority encoder, plus a `one_hot_or_zero` flag used for out_last.

## Test plan
- in_board=0x0000_0001 → one beat: index 0, seq 0, last=1, none=0; then IDLE, in_ready=1.
- in_board=0x8000_0005 → three beats: indices 0, 2, 31; seq 0, 1, 2; last only on index 31.
- in_board=0x0000_0000 → one beat: none=1, index 0, last=1; busy drops the next cycle.
- Backpressure: in_board=0x0000_0030 with out_ready low for 3 cycles → index 4 and seq 0 held stable for all 3 cycles. After release, index 5 (last) follows.
- Back-to-back: 0x0000_0002 then 0x0000_0100, with in_valid held → index 1 (last) and index 8 on consecutive cycles, no bubble.
- Reset mid-board:
  - Apply 0xFFFF_FFFF; after 10 beats, pull reset low → out_valid=0 and busy=0 immediately, asynchronously.
  - After release: in_ready=1, no stale beats appear, and a new board 0x0000_0004 yields index 2, seq 0.

Source files
------------

// File: rtl/checkers_pkg.sv
// Shared checkers constants: board geometry and bitboard-scanner state encoding.
// The ALU and move-list builder reuse BOARD_W from here.
package checkers_pkg;
  localparam int BOARD_W = 32;
  localparam int IDX_W   = 5;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_EMIT = 1'b1
  } scan_state_e;
endpackage

// File: rtl/lsb_index.sv
// Lowest-set-bit priority encoder over a bitboard, plus a flag telling whether
// at most one bit is set (the board is on its final square).
module lsb_index
  import checkers_pkg::*;
#(
  parameter int BOARD_W = checkers_pkg::BOARD_W,
  parameter int IDX_W   = checkers_pkg::IDX_W
) (
  input  logic [BOARD_W-1:0] board,
  output logic [IDX_W-1:0]   index,
  output logic               one_hot_or_zero
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = BOARD_W - 1; i >= 0; i--) begin
      if (board[i]) index = IDX_W'(i);
    end
  end

  assign one_hot_or_zero = ~|(board & (board - BOARD_W'(1)));

endmodule

// File: rtl/bitboard_scanner.sv
// Streams the square index of every set bit of an accepted bitboard, lowest
// first, one beat per cycle; a zero board yields a single "none" beat.
module bitboard_scanner
  import checkers_pkg::*;
#(
  parameter int BOARD_W = checkers_pkg::BOARD_W,
  parameter int IDX_W   = checkers_pkg::IDX_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BOARD_W-1:0] in_board,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_index,
  output logic [IDX_W-1:0]   out_seq,
  output logic               out_last,
  output logic               out_none,
  output logic               busy
);

  scan_state_e        state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [IDX_W-1:0]   seq_q, seq_d;
  logic               none_q, none_d;

  logic [IDX_W-1:0]   lsb_idx;
  logic               lsb_oh;
  logic               emit;
  logic               beat_xfer;
  logic               load;

  lsb_index #(
    .BOARD_W (BOARD_W),
    .IDX_W   (IDX_W)
  ) u_lsb (
    .board           (board_q),
    .index           (lsb_idx),
    .one_hot_or_zero (lsb_oh)
  );

  // Outputs are gated by state so a stale board_q never leaks while idle.
  assign emit      = (state_q == SCAN_EMIT);
  assign out_valid = emit;
  assign out_index = (emit && !none_q) ? lsb_idx : '0;
  assign out_seq   = emit ? seq_q : '0;
  assign out_last  = emit & (none_q | lsb_oh);
  assign out_none  = emit & none_q;
  assign busy      = emit;

  assign beat_xfer = out_valid & out_ready;
  assign in_ready  = ~emit | (beat_xfer & out_last);
  assign load      = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    seq_d   = seq_q;
    none_d  = none_q;
    if (load) begin
      board_d = in_board;
      seq_d   = '0;
      none_d  = (in_board == '0);
      state_d = SCAN_EMIT;
    end else if (beat_xfer) begin
      if (out_last) begin
        state_d = SCAN_IDLE;
      end else begin
        board_d = board_q & (board_q - BOARD_W'(1));
        seq_d   = seq_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN_IDLE;
      board_q <= '0;
      seq_q   <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      seq_q   <= seq_d;
      none_q  <= none_d;
    end
  end

endmodule

// File: tb/tb_bitboard_scanner.sv
// Scoreboard bench for bitboard_scanner: directed cases from the plan plus
// randomized boards with random backpressure against a set-bit list model.
module tb_bitboard_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_board = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_index;
  logic [4:0]  out_seq;
  logic        out_last;
  logic        out_none;
  logic        busy;

  bitboard_scanner #(.BOARD_W(32), .IDX_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_board  (in_board),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_seq   (out_seq),
    .out_last  (out_last),
    .out_none  (out_none),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int idx;
    int seq;
    bit last;
    bit none;
  } beat_t;

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    rnd_rdy = 1'b0;

  // Reference: list every set square in ascending order, seq = position in list.
  function automatic void push_board(input logic [31:0] b);
    int    pos[$];
    beat_t e;
    for (int i = 0; i < 32; i++) if (b[i]) pos.push_back(i);
    if (pos.size() == 0) begin
      e = '{idx: 0, seq: 0, last: 1'b1, none: 1'b1};
      sb.push_back(e);
    end else begin
      for (int k = 0; k < pos.size(); k++) begin
        e = '{idx: pos[k], seq: k, last: (k == pos.size() - 1), none: 1'b0};
        sb.push_back(e);
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops on every transferred beat, and checks stability under stall.
  beat_t      exp_b;
  bit         stalled = 1'b0;
  logic [11:0] snap;
  always @(negedge clock) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got index %0d seq %0d, expected no beat", out_index, out_seq);
        end else begin
          exp_b = sb.pop_front();
          n_tests++;
          if (int'(out_index) != exp_b.idx || int'(out_seq) != exp_b.seq ||
              out_last != exp_b.last || out_none != exp_b.none) begin
            n_fail++;
            $display("FAIL beat: got idx=%0d seq=%0d last=%0d none=%0d, expected idx=%0d seq=%0d last=%0d none=%0d",
                     out_index, out_seq, out_last, out_none, exp_b.idx, exp_b.seq, exp_b.last, exp_b.none);
          end
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        if (stalled) check("stall_hold", int'({out_index, out_seq, out_last, out_none}), int'(snap));
        snap    = {out_index, out_seq, out_last, out_none};
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Offer a board until accepted; inputs change only #1 after a rising edge.
  task automatic send(input logic [31:0] b);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_board = b;
    for (int c = 0; c < 300 && !done; c++) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (in_ready) begin
        push_board(b);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_board = $urandom;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: board %h never accepted, expected acceptance", b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 4000 && sb.size() > 0; c++) begin
      out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clock);
      #1;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    logic [31:0] b;

    // Reset state
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_seq", out_seq, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_none", out_none, 0);
    check("rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single bit: first beat valid the cycle after acceptance
    send(32'h0000_0001);
    check("single_valid", out_valid, 1);
    check("single_last", out_last, 1);
    drain();
    check("single_idle_ready", in_ready, 1);
    check("single_idle_busy", busy, 0);

    // Three squares incl. the top one
    send(32'h8000_0005);
    drain();

    // Zero board: one none beat, busy drops next cycle
    send(32'h0000_0000);
    check("zero_busy", busy, 1);
    check("zero_none", out_none, 1);
    check("zero_index", out_index, 0);
    @(posedge clock);
    #1;
    check("zero_busy_after", busy, 0);

    // Backpressure for three cycles
    out_ready = 1'b0;
    send(32'h0000_0030);
    repeat (3) begin
      @(negedge clock);
      check("bp_valid", out_valid, 1);
      check("bp_index", out_index, 4);
      check("bp_seq", out_seq, 0);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back boards with no bubble
    send(32'h0000_0002);
    send(32'h0000_0100);
    @(negedge clock);
    check("b2b_valid", out_valid, 1);
    check("b2b_index", out_index, 8);
    @(posedge clock);
    #1;
    drain();

    // Reset mid-board
    send(32'hFFFF_FFFF);
    repeat (10) @(posedge clock);
    #1;
    check("mid_seq_before_rst", out_seq, 10);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    idle(5);
    check("post_rst_no_beat", out_valid, 0);
    send(32'h0000_0004);
    check("post_rst_index", out_index, 2);
    check("post_rst_seq", out_seq, 0);
    drain();

    // Randomized boards with random backpressure and gaps
    rnd_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2, 3, 4: b = $urandom & $urandom & $urandom;
        5:       b = 32'd1 << $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      send(b);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rnd_rdy = 1'b0;
    drain();
    idle(1);
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
